// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between fetch (0), execute (1) and I/O-DMA (2).
// i_mem_rdata is sampled on the edge that closes the RD_LAT-th cycle, counting the o_mem_en cycle as the first.
module mem_arbiter #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 12,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [2:0]          i_req,
  input  logic [2:0]          i_we,
  input  logic [2:0]          i_lock,
  input  logic [3*AWIDTH-1:0] i_addr,
  input  logic [3*DWIDTH-1:0] i_wdata,
  output logic [2:0]          o_gnt,
  output logic [2:0]          o_ack,
  output logic [DWIDTH-1:0]   o_rdata,
  output logic                o_mem_en,
  output logic                o_mem_we,
  output logic [AWIDTH-1:0]   o_mem_addr,
  output logic [DWIDTH-1:0]   o_mem_wdata,
  input  logic [DWIDTH-1:0]   i_mem_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  // WAIT lasts RD_LAT-1 cycles; the counter counts down to zero.
  localparam logic [1:0] WAIT_LOAD = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  logic [1:0]        r_state;
  logic [1:0]        r_ptr;
  logic [1:0]        r_win;
  logic              r_lock_hold;
  logic [1:0]        r_cnt;
  logic [2:0]        r_gnt;
  logic [2:0]        r_ack;
  logic [DWIDTH-1:0] r_rdata;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [AWIDTH-1:0] r_mem_addr;
  logic [DWIDTH-1:0] r_mem_wdata;

  logic [1:0]        w_rr_sel;
  logic              w_lock_win;
  logic [1:0]        w_sel;
  logic [1:0]        w_sel_next;

  function automatic logic [2:0] onehot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_rr_sel = 2'd0;
    // Walk from lowest to highest priority; the last hit is the highest-priority requester.
    for (int k = 2; k >= 0; k--) begin
      int idx;
      idx = (int'(r_ptr) + k) % 3;
      if (i_req[idx]) w_rr_sel = 2'(idx);
    end
    w_lock_win = r_lock_hold & i_req[r_win];
    w_sel      = w_lock_win ? r_win : w_rr_sel;
    w_sel_next = (w_sel == 2'd2) ? 2'd0 : w_sel + 2'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= 2'd0;
      r_win       <= 2'd0;
      r_lock_hold <= 1'b0;
      r_cnt       <= 2'd0;
      r_gnt       <= 3'b000;
      r_ack       <= 3'b000;
      r_rdata     <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|i_req) begin
            r_win       <= w_sel;
            // A locked re-grant leaves the rotation where it was.
            r_ptr       <= w_lock_win ? r_ptr : w_sel_next;
            r_lock_hold <= 1'b0;
            r_gnt       <= onehot(w_sel);
            r_mem_en    <= 1'b1;
            r_mem_we    <= i_we[w_sel];
            r_mem_addr  <= i_addr[w_sel*AWIDTH +: AWIDTH];
            r_mem_wdata <= i_wdata[w_sel*DWIDTH +: DWIDTH];
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_mem_en <= 1'b0;
          if (r_mem_we || RD_LAT == 1) begin
            r_ack   <= onehot(r_win);
            if (!r_mem_we) r_rdata <= i_mem_rdata;
            r_state <= S_ACK;
          end else begin
            r_cnt   <= WAIT_LOAD;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == 2'd0) begin
            r_ack   <= onehot(r_win);
            r_rdata <= i_mem_rdata;
            r_state <= S_ACK;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        S_ACK: begin
          r_ack       <= 3'b000;
          r_gnt       <= 3'b000;
          r_lock_hold <= i_lock[r_win];
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_gnt       = r_gnt;
  assign o_ack       = r_ack;
  assign o_rdata     = r_rdata;
  assign o_mem_en    = r_mem_en;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (RD_LAT 1..3) share one memory model; only the selected one is driven.
module tb_mem_arbiter;
  localparam int DW = 16;
  localparam int AW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n = 1'b0;
  logic [2:0]    req = '0, we = '0, lock = '0;
  logic [3*AW-1:0] addr = '0;
  logic [3*DW-1:0] wdata = '0;
  logic [1:0]    sel = 2'd1;

  logic [2:0]    gnt_a [1:3];
  logic [2:0]    ack_a [1:3];
  logic [DW-1:0] rdata_a [1:3];
  logic          en_a [1:3];
  logic          mwe_a [1:3];
  logic [AW-1:0] maddr_a [1:3];
  logic [DW-1:0] mwdata_a [1:3];

  logic [2:0]    gnt, ack;
  logic [DW-1:0] rdata, mwdata;
  logic          en, mwe;
  logic [AW-1:0] maddr;

  always_comb begin
    gnt    = gnt_a[sel];
    ack    = ack_a[sel];
    rdata  = rdata_a[sel];
    en     = en_a[sel];
    mwe    = mwe_a[sel];
    maddr  = maddr_a[sel];
    mwdata = mwdata_a[sel];
  end

  // Memory environment: read data appears in the o_mem_en cycle and is delayed per latency.
  logic [DW-1:0] ram [4096];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;
  logic          pv0, pv1, pv2;
  logic [DW-1:0] pd0, pd1, pd2, mrd1, mrd2, mrd3;

  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (en && mwe) ram[maddr] <= mwdata;
  end
  assign pv0 = en && !mwe;
  assign pd0 = ram[maddr];
  always @(posedge clk) begin
    pv1 <= pv0; pd1 <= pd0;
    pv2 <= pv1; pd2 <= pd1;
  end
  assign mrd1 = pv0 ? pd0 : 16'hDEAD;
  assign mrd2 = pv1 ? pd1 : 16'hDEAD;
  assign mrd3 = pv2 ? pd2 : 16'hDEAD;

  for (genvar g = 1; g <= 3; g++) begin : g_dut
    mem_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .RD_LAT(g)) u_dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_req       ((sel == 2'(g)) ? req : 3'b000),
      .i_we        (we),
      .i_lock      (lock),
      .i_addr      (addr),
      .i_wdata     (wdata),
      .o_gnt       (gnt_a[g]),
      .o_ack       (ack_a[g]),
      .o_rdata     (rdata_a[g]),
      .o_mem_en    (en_a[g]),
      .o_mem_we    (mwe_a[g]),
      .o_mem_addr  (maddr_a[g]),
      .o_mem_wdata (mwdata_a[g]),
      .i_mem_rdata ((g == 1) ? mrd1 : (g == 2) ? mrd2 : mrd3)
    );
  end

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] ref_mem [4096];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic r, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    req[p] = r;
    we[p]  = w;
    addr[p*AW +: AW] = a;
    wdata[p*DW +: DW] = d;
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    req = '0;
    lock = '0;
    repeat (n) tick();
    reset_n = 1'b1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we = 1'b1;
    tick();
    pre_we = 1'b0;
    ref_mem[a] = d;
  endtask

  function automatic int oh2i(input logic [2:0] v);
    return v[1] ? 1 : (v[2] ? 2 : 0);
  endfunction

  // One isolated transaction on port p; exp_off is the cycle offset of the ack after the request cycle.
  task automatic run_single(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [DW-1:0] exp_rd, input int exp_off, input bit early_drop,
                            input string tag);
    int en_cnt;
    int got;
    en_cnt = 0;
    got = 0;
    set_port(p, 1'b1, w, a, d);
    for (int c = 1; c <= 8 && got == 0; c++) begin
      tick();
      if (en) begin
        en_cnt++;
        check({tag, "_maddr"}, maddr, a);
        check({tag, "_mwe"}, mwe, w);
        if (w) check({tag, "_mwdata"}, mwdata, d);
      end
      if (early_drop && c == 1) req[p] = 1'b0;
      if (ack != 3'b000) begin
        got = c;
        check({tag, "_ack"}, ack, 3'b001 << p);
        if (!w) check({tag, "_rdata"}, rdata, exp_rd);
        set_port(p, 1'b0, 1'b0, '0, '0);
      end
    end
    check({tag, "_ack_cycle"}, got, exp_off);
    set_port(p, 1'b0, 1'b0, '0, '0);
    tick();
    check({tag, "_idle_gnt"}, gnt, 3'b000);
    check({tag, "_en_pulses"}, en_cnt, 1);
  endtask

  task automatic new_req(input int p);
    set_port(p, 1'b1, 1'($urandom_range(0, 1)), 12'h300 + 12'($urandom_range(0, 15)), 16'($urandom));
  endtask

  // Transaction-level reference: decide winners from the round-robin/lock rules, predict timing from latency.
  task automatic random_phase(input int lat, input int n);
    int iss_c, ack_c, win, ptr;
    bit lock_hold, t_we;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wd, t_rd, last_rd;
    iss_c = -1; ack_c = -1; win = 0; ptr = 0; lock_hold = 0;
    t_we = 0; t_addr = '0; t_wd = '0; t_rd = '0; last_rd = '0;
    for (int cyc = 0; cyc < n; cyc++) begin
      tick();
      check("rnd_gnt", gnt, (cyc >= iss_c && cyc <= ack_c) ? (3'b001 << win) : 3'b000);
      check("rnd_en", en, cyc == iss_c);
      check("rnd_ack", ack, (cyc == ack_c) ? (3'b001 << win) : 3'b000);
      if (cyc == iss_c) begin
        check("rnd_maddr", maddr, t_addr);
        check("rnd_mwe", mwe, t_we);
        if (t_we) check("rnd_mwdata", mwdata, t_wd);
      end
      if (cyc == ack_c && !t_we) last_rd = t_rd;
      check("rnd_rdata", rdata, last_rd);

      lock = 3'($urandom);
      for (int p = 0; p < 3; p++) begin
        if (cyc == ack_c && p == win) begin
          if ($urandom_range(0, 1) == 1) new_req(p);
          else req[p] = 1'b0;
        end else if (cyc >= iss_c && cyc < ack_c && p == win) begin
          set_port(p, 1'b1, 1'($urandom_range(0, 1)), 12'($urandom), 16'($urandom));
        end else if (!req[p] && $urandom_range(0, 2) == 0) begin
          new_req(p);
        end
      end

      if (cyc == ack_c) lock_hold = lock[win];
      if (cyc > ack_c && req != 3'b000) begin
        if (!(lock_hold && req[win])) begin
          for (int k = 2; k >= 0; k--)
            if (req[(ptr + k) % 3]) win = (ptr + k) % 3;
          ptr = (win + 1) % 3;
        end
        lock_hold = 0;
        t_we   = we[win];
        t_addr = addr[win*AW +: AW];
        t_wd   = wdata[win*DW +: DW];
        if (t_we) ref_mem[t_addr] = t_wd;
        else t_rd = ref_mem[t_addr];
        iss_c = cyc + 1;
        ack_c = cyc + 1 + (t_we ? 1 : lat);
      end
    end
    req = '0;
    lock = '0;
    repeat (6) tick();
  endtask

  initial begin
    int order[$];
    logic [2:0] prev_ack;
    logic [DW-1:0] rd_val;
    bit rd_done;
    int got;

    // Reset and single write on the RD_LAT=1 instance.
    sel = 2'd1;
    do_reset(2);
    check("rst_gnt", gnt, 3'b000);
    check("rst_ack", ack, 3'b000);
    check("rst_en", en, 1'b0);
    check("rst_mwe", mwe, 1'b0);
    check("rst_maddr", maddr, 12'h000);
    check("rst_mwdata", mwdata, 16'h0000);
    check("rst_rdata", rdata, 16'h0000);
    set_port(0, 1'b1, 1'b1, 12'h123, 16'hBEEF);
    tick();
    check("wr_en", en, 1'b1);
    check("wr_mwe", mwe, 1'b1);
    check("wr_maddr", maddr, 12'h123);
    check("wr_mwdata", mwdata, 16'hBEEF);
    check("wr_gnt", gnt, 3'b001);
    check("wr_ack_early", ack, 3'b000);
    set_port(0, 1'b1, 1'b0, 12'hFFF, 16'h0000);
    tick();
    check("wr_ack", ack, 3'b001);
    check("wr_en_single", en, 1'b0);
    check("wr_gnt_hold", gnt, 3'b001);
    set_port(0, 1'b0, 1'b0, '0, '0);
    tick();
    check("wr_idle_gnt", gnt, 3'b000);
    check("wr_idle_ack", ack, 3'b000);

    // Preload memory locations used later.
    preload(12'h010, 16'h0041);
    for (int i = 0; i < 16; i++) preload(12'h300 + 12'(i), 16'($urandom));

    // Read latency sweep.
    for (int l = 1; l <= 3; l++) begin
      sel = 2'(l);
      run_single(1, 1'b0, 12'h123, 16'h0000, 16'hBEEF, 1 + l, 1'b0, $sformatf("rd_lat%0d", l));
    end

    // Early drop of i_req during ISSUE, then read the written word back.
    sel = 2'd1;
    run_single(2, 1'b1, 12'h124, 16'h5A5A, 16'h0000, 2, 1'b1, "edrop");
    run_single(0, 1'b0, 12'h124, 16'h0000, 16'h5A5A, 2, 1'b0, "edrop_rd");

    // Round robin with all three ports requesting, each resting one cycle after its ack.
    do_reset(1);
    for (int p = 0; p < 3; p++) set_port(p, 1'b1, 1'b1, 12'h200 + 12'(p), 16'h1000 + 16'(p));
    prev_ack = 3'b000;
    for (int c = 0; c < 60 && order.size() < 6; c++) begin
      tick();
      req = 3'b111 & ~prev_ack;
      prev_ack = ack;
      if (en) order.push_back(oh2i(gnt));
    end
    for (int i = 0; i < 6; i++)
      check($sformatf("rr_%0d", i), (i < order.size()) ? order[i] : 99, i % 3);
    req = '0;
    repeat (4) tick();

    // Locked read-modify-write on port 1 against competing ports 0 and 2.
    do_reset(1);
    order.delete();
    rd_done = 0;
    rd_val = '0;
    set_port(0, 1'b1, 1'b1, 12'h201, 16'h1111);
    set_port(1, 1'b1, 1'b0, 12'h010, 16'h0000);
    set_port(2, 1'b1, 1'b1, 12'h202, 16'h2222);
    lock = 3'b010;
    for (int c = 0; c < 60 && order.size() < 4; c++) begin
      tick();
      if (en) order.push_back(oh2i(gnt));
      for (int p = 0; p < 3; p++) begin
        if (ack[p]) begin
          if (p == 1 && !rd_done) begin
            rd_done = 1;
            rd_val = rdata;
            set_port(1, 1'b1, 1'b1, 12'h010, rdata + 16'h0001);
          end else begin
            set_port(p, 1'b0, 1'b0, '0, '0);
          end
        end
      end
    end
    for (int i = 0; i < 4; i++)
      check($sformatf("lock_order_%0d", i), (i < order.size()) ? order[i] : 99, (i == 0) ? 0 : (i == 3) ? 2 : 1);
    check("lock_rd_val", rd_val, 16'h0041);
    req = '0;
    repeat (5) tick();
    lock = '0;
    check("lock_mem", ram[12'h010], 16'h0042);

    // Reset during WAIT on the RD_LAT=3 instance.
    sel = 2'd3;
    run_single(1, 1'b0, 12'h123, 16'h0000, 16'hBEEF, 4, 1'b0, "r3_pre");
    set_port(1, 1'b1, 1'b0, 12'h123, 16'h0000);
    tick();
    check("mrst_issue_en", en, 1'b1);
    tick();
    check("mrst_wait_gnt", gnt, 3'b010);
    reset_n = 1'b0;
    set_port(1, 1'b0, 1'b0, '0, '0);
    tick();
    check("mrst_gnt", gnt, 3'b000);
    check("mrst_ack", ack, 3'b000);
    check("mrst_en", en, 1'b0);
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("mrst_no_ack", ack, 3'b000);
    end
    for (int p = 0; p < 3; p++) set_port(p, 1'b1, 1'b0, 12'h123, 16'h0000);
    got = 0;
    for (int c = 0; c < 6 && got == 0; c++) begin
      tick();
      if (en) begin
        got = 1;
        check("mrst_first_gnt", gnt, 3'b001);
        req = '0;
      end
    end
    check("mrst_granted", got, 1);
    req = '0;
    got = 0;
    for (int c = 0; c < 8 && got == 0; c++) begin
      tick();
      if (ack != 3'b000) begin
        got = 1;
        check("mrst_after_ack", ack, 3'b001);
        check("mrst_after_rdata", rdata, 16'hBEEF);
      end
    end
    check("mrst_after_done", got, 1);
    repeat (3) tick();

    // Randomised traffic against the reference model.
    sel = 2'd1;
    do_reset(1);
    random_phase(1, 300);
    sel = 2'd3;
    do_reset(1);
    random_phase(3, 300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
